fa: RTL and testbench

FA -- requirements
Module: fa

---
 rtl/fa_if.sv | 12 +
 rtl/fa.sv | 43 ++++
 tb/tb_fa.sv | 106 ++++++++++
 3 files changed

// File: rtl/fa_if.sv
// fa_if: operand/result bundle for the fa adder.
interface fa_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic c_in;
  logic in_valid;
  logic c_out;
  logic out_valid;
  modport master (output a, b, c_in, in_valid, input sum, c_out, out_valid);
  modport slave (input a, b, c_in, in_valid, output sum, c_out, out_valid);
endinterface

// File: rtl/fa.sv
// fa: ripple-carry adder of WIDTH full-adder cells with optional registered outputs.
module fa #(
  parameter int WIDTH = 1,
  parameter bit REG_OUT = 1
) (
  input logic clk,
  input logic rst,
  fa_if.slave bus
);
  logic [WIDTH:0] carry;
  logic [WIDTH-1:0] sum_d;
  assign carry[0] = bus.c_in;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign sum_d[i] = bus.a[i] ^ bus.b[i] ^ carry[i];
    assign carry[i+1] = (bus.a[i] & bus.b[i]) | (bus.a[i] & carry[i]) | (bus.b[i] & carry[i]);
  end
  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic c_out_q;
    logic out_valid_q;
    // result registers load only on valid input, so idle-cycle X never reaches them
    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
        c_out_q <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          sum_q <= sum_d;
          c_out_q <= carry[WIDTH];
        end
      end
    end
    assign bus.sum = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.out_valid = out_valid_q;
  end else begin : g_comb
    assign bus.sum = sum_d;
    assign bus.c_out = carry[WIDTH];
    assign bus.out_valid = bus.in_valid;
  end
endmodule

// File: tb/tb_fa.sv
// tb_fa: directed and random checks of fa in four width/register configurations.
module tb_fa;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fa_if #(1) i1 ();
  fa_if #(8) i8 ();
  fa_if #(1) i0 ();
  fa_if #(16) i16 ();
  fa #(.WIDTH(1), .REG_OUT(1)) u1 (.clk(clk), .rst(rst), .bus(i1.slave));
  fa #(.WIDTH(8), .REG_OUT(1)) u8 (.clk(clk), .rst(rst), .bus(i8.slave));
  fa #(.WIDTH(1), .REG_OUT(0)) u0 (.clk(clk), .rst(rst), .bus(i0.slave));
  fa #(.WIDTH(16), .REG_OUT(1)) u16 (.clk(clk), .rst(rst), .bus(i16.slave));
  logic [2:0] v1 [8] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
  logic [1:0] e1 [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
  logic [16:0] exp16;
  logic v16;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    {i1.a, i1.b, i1.c_in, i1.in_valid} = '0;
    {i8.a, i8.b, i8.c_in, i8.in_valid} = '0;
    {i0.a, i0.b, i0.c_in, i0.in_valid} = '0;
    {i16.a, i16.b, i16.c_in, i16.in_valid} = '0;
    rst = 1'b1;
    step();
    step();
    check("rst_w1", {61'd0, i1.out_valid, i1.c_out, i1.sum}, 64'd0);
    check("rst_w8", {54'd0, i8.out_valid, i8.c_out, i8.sum}, 64'd0);
    check("rst_w16", {46'd0, i16.out_valid, i16.c_out, i16.sum}, 64'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      {i1.a, i1.b, i1.c_in} = v1[k];
      i1.in_valid = 1'b1;
      step();
      check($sformatf("w1_vec%0d", k), {62'd0, i1.c_out, i1.sum}, {62'd0, e1[k]});
      check($sformatf("w1_ov%0d", k), {63'd0, i1.out_valid}, 64'd1);
    end
    {i1.a, i1.b, i1.c_in, i1.in_valid} = 4'b1111;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_prio", {61'd0, i1.out_valid, i1.c_out, i1.sum}, 64'd0);
    {i1.a, i1.b, i1.c_in, i1.in_valid} = 4'b1001;
    step();
    check("hold_load", {61'd0, i1.out_valid, i1.c_out, i1.sum}, 64'b101);
    i1.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      {i1.a, i1.b, i1.c_in} = 3'(k * 3 + 2);
      step();
      check($sformatf("hold%0d", k), {61'd0, i1.out_valid, i1.c_out, i1.sum}, 64'b001);
    end
    i1.a = 'x;
    i1.c_in = 'x;
    step();
    check("hold_x", {61'd0, i1.out_valid, i1.c_out, i1.sum}, 64'b001);
    i8.in_valid = 1'b1;
    {i8.a, i8.b, i8.c_in} = {8'hFF, 8'h01, 1'b0};
    step();
    check("w8_a", {55'd0, i8.c_out, i8.sum}, 64'h100);
    {i8.a, i8.b, i8.c_in} = {8'h7F, 8'h80, 1'b1};
    step();
    check("w8_b", {55'd0, i8.c_out, i8.sum}, 64'h100);
    {i8.a, i8.b, i8.c_in} = {8'h12, 8'h34, 1'b1};
    step();
    check("w8_c", {55'd0, i8.c_out, i8.sum}, 64'h047);
    {i8.a, i8.b, i8.c_in} = {8'hFF, 8'hFF, 1'b1};
    step();
    check("w8_ones", {55'd0, i8.c_out, i8.sum}, 64'h1FF);
    i8.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      {i0.a, i0.b, i0.c_in} = v1[k];
      i0.in_valid = 1'(k & 1);
      #1;
      check($sformatf("comb_vec%0d", k), {62'd0, i0.c_out, i0.sum}, {62'd0, e1[k]});
      check($sformatf("comb_ov%0d", k), {63'd0, i0.out_valid}, 64'(k & 1));
      #19;
    end
    exp16 = '0;
    step();
    for (int n = 0; n < 1000; n++) begin
      i16.a = 16'($urandom);
      i16.b = 16'($urandom);
      i16.c_in = 1'($urandom_range(0, 1));
      v16 = ($urandom_range(0, 3) != 0);
      i16.in_valid = v16;
      if (v16) exp16 = 17'(i16.a) + 17'(i16.b) + 17'(i16.c_in);
      step();
      check("rand_sum", {47'd0, i16.c_out, i16.sum}, {47'd0, exp16});
      check("rand_ov", {63'd0, i16.out_valid}, {63'd0, v16});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
